dt_batch_aggregator: RTL
========================

// Module: dt_batch_aggregator
// PURPOSE
//  Downstream sequencer/consumer for the decision-tree classifier core.
//  - On one batch request, issues NUM_SAMPLES start pulses to the tree, one per sample.
//  - Captures each class result on the rising edge of the tree's done signal.
//  - Keeps per-class tallies and produces a batch-level malaria verdict (infected / clean).
//  - Guards each classification with a watchdog.
// PARAMETERS
//  NUM_SAMPLES    16    classifications per batch (1 .. 2**CNT_W-1)
//  CNT_W          8     width of each tally counter and of the sample index
//  TIMEOUT_CYCLES 1024  max cycles from dt_start to the done rising edge
//  INFECT_THRESH  4     infected tally >= this sets verdict_infected
// PORTS
//  clk              in   1      system clock, rising edge
//  rst              in   1      asynchronous, active-low reset
//  batch_start      in   1      1-cycle request to run a batch; ignored unless IDLE
//  dt_start         out  1      1-cycle start pulse to the decision-tree core
//  dt_class         in   2      class result from the core (class_out)
//  dt_done          in   1      core done level (process_done)
//  busy             out  1      high from batch accept until batch_done
//  cnt_clean        out  CNT_W  tally of CLS_CLEAN results
//  cnt_infected     out  CNT_W  tally of CLS_INFECTED results
//  cnt_other        out  CNT_W  tally of CLS_OTHER and CLS_INVALID results
//  batch_done       out  1      1-cycle pulse when the batch ends (normal or timeout)
//  verdict_infected out  1      valid from batch_done until next accept; cnt_infected >= INFECT_THRESH
//  timeout_err      out  1      sticky until next accept; the batch was aborted by the watchdog
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - All outputs, counters and state clear to 0; FSM goes to IDLE.
//   - Mid-batch reset abandons the batch; dt_start drops immediately.
//  Done detection:
//   - done_q <= dt_done every cycle.
//   - done_rise = dt_done & ~done_q.
//   - Only done_rise counts as a result; a level held high from the previous sample is never recounted.
//  FSM states: IDLE, ISSUE, WAIT, RECORD, FINISH.
//   IDLE:
//    - On batch_start, clear all tallies, idx, timeout_err and verdict_infected.
//    - Set busy=1 and go to ISSUE.
//   ISSUE:
//    - dt_start=1 for exactly this cycle; wdog cleared to 0; go to WAIT.
//   WAIT:
//    - wdog increments each cycle.
//    - If done_rise: latch dt_class and go to RECORD.
//    - Else if wdog == TIMEOUT_CYCLES-1: set timeout_err=1 and go to FINISH.
//    - done_rise takes priority over timeout in the same cycle.
//   RECORD:
//    - Increment the matching tally; idx++.
//    - If idx == NUM_SAMPLES-1 (before increment), go to FINISH; else go to ISSUE.
//   FINISH:
//    - verdict_infected <= (cnt_infected >= INFECT_THRESH), computed on the final tallies.
//    - batch_done=1 for 1 cycle; busy=0; go to IDLE.
//    - On a timeout batch, the verdict still reflects the partial tallies.
//  Per-sample overhead:
//   - ISSUE to the next ISSUE is (core latency + 2) cycles.
//   - batch_done follows the last RECORD by 1 cycle.
//  Arithmetic:
//   - Tallies saturate at 2**CNT_W-1 and never wrap.
//   - Comparison is unsigned.
//   - The three tallies always sum to the number of RECORD cycles.
//  Boundaries:
//   - batch_start while busy is ignored.
//   - batch_start in the FINISH cycle is ignored; the next one is accepted in IDLE.
//   - dt_done or dt_class activity while IDLE is ignored.
//   - NUM_SAMPLES=1: a single ISSUE/WAIT/RECORD, then FINISH.
// STRUCTURE
//  Shared package dt_pkg holds:
//   - Class codes: CLS_CLEAN=2'b00, CLS_INFECTED=2'b01, CLS_OTHER=2'b10, CLS_INVALID=2'b11.
//   - FSM state encoding, 3-bit.
//  One sub-module, dt_sat_counter:
//   - CNT_W wide, with clear, enable and saturation; instantiated three times.
//  FSM, watchdog and done edge detector stay in this module.
// TESTING
//  1. Reset with NUM_SAMPLES=4, then batch_start; the model core returns 01,01,00,10:
//     -> 4 dt_start pulses, cnt_infected=2, cnt_clean=1, cnt_other=1, verdict_infected=0 (THRESH=4).
//  2. Default params, core returns 01 for all 16 samples:
//     -> cnt_infected=16, verdict_infected=1, batch_done pulses exactly once, busy low afterwards.
//  3. Core never raises done, TIMEOUT_CYCLES=32:
//     -> batch_done 33-34 cycles after the first dt_start, timeout_err=1, all tallies 0.
//  4. Core holds dt_done high and only clears it on the next start:
//     -> each sample counted once; 16 results total, no double counting.
//  5. batch_start re-pulsed during WAIT, then rst=0 asserted mid-batch:
//     -> re-pulse ignored; outputs 0 immediately on reset, dt_start low; a fresh batch afterwards runs normally.
//  6. CNT_W=3, NUM_SAMPLES=7, core returns 11 for all samples:
//     -> cnt_other=7, no wrap, verdict_infected=0.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree batch aggregator: class codes and FSM encoding.
package dt_pkg;

  localparam logic [1:0] CLS_CLEAN    = 2'b00;
  localparam logic [1:0] CLS_INFECTED = 2'b01;
  localparam logic [1:0] CLS_OTHER    = 2'b10;
  localparam logic [1:0] CLS_INVALID  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RECORD = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/dt_sat_counter.sv
// Tally counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module dt_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dt_batch_aggregator.sv
// Batch sequencer for the decision-tree core: issues one start per sample, tallies the
// class results, watchdogs each classification and produces an infected/clean verdict.
module dt_batch_aggregator
  import dt_pkg::*;
#(
  parameter int NUM_SAMPLES    = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int INFECT_THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             batch_start,
  output logic             dt_start,
  input  logic [1:0]       dt_class,
  input  logic             dt_done,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_clean,
  output logic [CNT_W-1:0] cnt_infected,
  output logic [CNT_W-1:0] cnt_other,
  output logic             batch_done,
  output logic             verdict_infected,
  output logic             timeout_err,
  output logic [2:0]       dbg_state
);

  // Protocol: batch_start is a 1-cycle request honoured only in IDLE (no back-pressure);
  // dt_start is a 1-cycle pulse; dt_done is a level and only its rising edge is a result.
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  IDX_LAST  = CNT_W'(NUM_SAMPLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]        class_q, class_d;
  logic              verdict_q, verdict_d;
  logic              tmo_q, tmo_d;
  logic              done_q;
  logic              done_rise;
  logic              clr_tally;
  logic              rec;
  logic              en_clean, en_infected, en_other;

  assign done_rise = dt_done & ~done_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wdog_d    = wdog_q;
    class_d   = class_q;
    verdict_d = verdict_q;
    tmo_d     = tmo_q;
    clr_tally = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (batch_start) begin
          clr_tally = 1'b1;
          idx_d     = '0;
          tmo_d     = 1'b0;
          verdict_d = 1'b0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // A result arriving on the watchdog's last cycle still counts.
        if (done_rise) begin
          class_d = dt_class;
          state_d = ST_RECORD;
        end else if (wdog_q == WDOG_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_RECORD: begin
        idx_d   = idx_q + CNT_W'(1);
        state_d = (idx_q == IDX_LAST) ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        verdict_d = ({{(32 - CNT_W){1'b0}}, cnt_infected} >= $unsigned(INFECT_THRESH));
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wdog_q    <= '0;
      class_q   <= '0;
      verdict_q <= 1'b0;
      tmo_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wdog_q    <= wdog_d;
      class_q   <= class_d;
      verdict_q <= verdict_d;
      tmo_q     <= tmo_d;
      done_q    <= dt_done;
    end
  end

  assign rec         = (state_q == ST_RECORD);
  assign en_clean    = rec && (class_q == CLS_CLEAN);
  assign en_infected = rec && (class_q == CLS_INFECTED);
  assign en_other    = rec && ((class_q == CLS_OTHER) || (class_q == CLS_INVALID));

  dt_sat_counter #(.CNT_W(CNT_W)) u_cnt_clean (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_tally),
    .en_i  (en_clean),
    .cnt_o (cnt_clean)
  );

  dt_sat_counter #(.CNT_W(CNT_W)) u_cnt_infected (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_tally),
    .en_i  (en_infected),
    .cnt_o (cnt_infected)
  );

  dt_sat_counter #(.CNT_W(CNT_W)) u_cnt_other (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_tally),
    .en_i  (en_other),
    .cnt_o (cnt_other)
  );

  assign dt_start         = (state_q == ST_ISSUE);
  assign busy             = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_RECORD);
  assign batch_done       = (state_q == ST_FINISH);
  assign verdict_infected = verdict_q;
  assign timeout_err      = tmo_q;
  assign dbg_state        = state_q;

endmodule
